uart_rx_framed: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_sampler.sv | 55 +++++
 rtl/uart_rx_framed.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity modes and the
// 3-sample majority helper used by the bit sampler.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit timer for the UART receiver: counts clocks within a bit, takes three
// samples around mid-bit and reports the majority at the decision point.
module uart_bit_sampler #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic rxs,
   input  logic restart,
   output logic bit_tick,
   output logic bit_val,
   output logic bit_end
);
   import uart_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int H  = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] CNT_PRE  = CW'(H - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(H);
   localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;
   logic          s_pre;
   logic          s_mid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         s_pre <= 1'b1;
         s_mid <= 1'b1;
      end else begin
         if (restart || cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (!restart && cnt == CNT_PRE) begin
            s_pre <= rxs;
         end
         if (!restart && cnt == CNT_MID) begin
            s_mid <= rxs;
         end
      end
   end

   // Third sample is the live synchronised line at the decision cycle.
   always_comb begin
      bit_tick = !restart && (cnt == CNT_DEC);
      bit_end  = !restart && (cnt == CNT_LAST);
      bit_val  = maj3(s_pre, s_mid, rxs);
   end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// per-frame status flags and a valid/ready output register with overrun pulse.
module uart_rx_framed #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_rx,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_overrun
);
   import uart_pkg::*;

   localparam int             BW         = $clog2(DATA_BITS);
   localparam logic [BW-1:0]  LAST_BIT   = BW'(DATA_BITS - 1);
   localparam logic           HAS_PARITY = (PARITY != PARITY_NONE);
   localparam logic           TWO_STOPS  = (STOP_BITS == 2);

   logic rx_meta;
   logic rxs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rxs     <= rx_meta;
      end
   end

   uart_state_t state;
   uart_state_t state_nx;
   logic        restart;
   logic        bit_tick;
   logic        bit_val;
   logic        bit_end;
   logic        done;

   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic                 par_acc;
   logic                 pbit;
   logic                 par_err;
   logic                 frame_err;
   logic                 stop1;
   logic                 last_stop;
   logic                 first_stop;
   logic                 fe_now;
   logic                 brk_now;

   uart_bit_sampler #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_sampler (
      .clk      (clk),
      .reset    (reset),
      .rxs      (rxs),
      .restart  (restart),
      .bit_tick (bit_tick),
      .bit_val  (bit_val),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Leaving STOP at the decision cycle lets IDLE catch a start edge that
   // arrives before the nominal end of the last stop bit.
   always_comb begin
      state_nx  = state;
      done      = 1'b0;
      restart   = (state == ST_IDLE);
      last_stop = !TWO_STOPS || stop_idx;
      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick && bit_val) begin
               state_nx = ST_IDLE;
            end else if (bit_end) begin
               state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end && bit_idx == LAST_BIT) begin
               state_nx = HAS_PARITY ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick && last_stop) begin
               state_nx = ST_IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg     <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         par_acc   <= 1'b0;
         pbit      <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         stop1     <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               bit_idx   <= '0;
               stop_idx  <= 1'b0;
               par_acc   <= 1'b0;
               pbit      <= 1'b0;
               par_err   <= 1'b0;
               frame_err <= 1'b0;
            end
            ST_DATA: begin
               if (bit_tick) begin
                  shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                  par_acc <= par_acc ^ bit_val;
               end
               if (bit_end) begin
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            ST_PARITY: begin
               if (bit_tick) begin
                  pbit    <= bit_val;
                  par_err <= (PARITY == PARITY_ODD) ? ~(par_acc ^ bit_val)
                                                    : (par_acc ^ bit_val);
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  if (!bit_val) begin
                     frame_err <= 1'b1;
                  end
                  if (!stop_idx) begin
                     stop1 <= bit_val;
                  end
               end
               if (bit_end) begin
                  stop_idx <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status for the completing frame includes the stop vote being decided now.
   always_comb begin
      fe_now     = frame_err | ~bit_val;
      first_stop = stop_idx ? stop1 : bit_val;
      brk_now    = (shreg == '0) && !(HAS_PARITY && pbit) && !first_stop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (done && (!o_valid || i_ready)) begin
            o_valid      <= 1'b1;
            o_data       <= shreg;
            o_parity_err <= par_err;
            o_frame_err  <= fe_now;
            o_break      <= brk_now;
         end else begin
            if (done) begin
               o_overrun <= 1'b1;
            end
            if (o_valid && i_ready) begin
               o_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: 8N1, 8E1, 8O1 and 9-bit/2-stop builds
// share one serial driver; a monitor records accepted frames and overruns.
module tb_uart_rx_framed;
   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       ready = 1'b0;
   logic [1:0] sel   = 2'd0;

   always #5 clk = ~clk;

   logic [3:0] rx_i, rdy_i, v, pe, fe, brk, ovr;
   logic [7:0] d0, d1, d2;
   logic [8:0] d3;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rx_i[k]  = (sel == 2'(k)) ? rx : 1'b1;
         rdy_i[k] = (sel == 2'(k)) ? ready : 1'b0;
      end
   end

   uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset(reset), .i_rx(rx_i[0]), .o_valid(v[0]), .i_ready(rdy_i[0]),
      .o_data(d0), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(brk[0]), .o_overrun(ovr[0]));
   uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset(reset), .i_rx(rx_i[1]), .o_valid(v[1]), .i_ready(rdy_i[1]),
      .o_data(d1), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(brk[1]), .o_overrun(ovr[1]));
   uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .reset(reset), .i_rx(rx_i[2]), .o_valid(v[2]), .i_ready(rdy_i[2]),
      .o_data(d2), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(brk[2]), .o_overrun(ovr[2]));
   uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_9n2 (
      .clk(clk), .reset(reset), .i_rx(rx_i[3]), .o_valid(v[3]), .i_ready(rdy_i[3]),
      .o_data(d3), .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_break(brk[3]), .o_overrun(ovr[3]));

   logic       cv, cpe, cfe, cbrk, covr;
   logic [8:0] cd;

   always_comb begin
      cv   = v[sel];
      cpe  = pe[sel];
      cfe  = fe[sel];
      cbrk = brk[sel];
      covr = ovr[sel];
      case (sel)
         2'd0:    cd = {1'b0, d0};
         2'd1:    cd = {1'b0, d1};
         2'd2:    cd = {1'b0, d2};
         default: cd = d3;
      endcase
   end

   int         checks  = 0;
   int         errors  = 0;
   int         acc_cnt = 0;
   int         ovr_cnt = 0;
   int         vcyc    = 0;
   logic [8:0] last_d  = '0;
   logic       last_pe = 1'b0;
   logic       last_fe = 1'b0;
   logic       last_brk = 1'b0;

   // Inputs change on the falling edge; sampling 2 ns later sees what the next rising edge will use.
   always begin
      @(negedge clk);
      #2;
      if (cv) vcyc++;
      if (covr) ovr_cnt++;
      if (cv && ready) begin
         acc_cnt++;
         last_d   = cd;
         last_pe  = cpe;
         last_fe  = cfe;
         last_brk = cbrk;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mkframe(input logic [8:0] d, input int nd, input int hp,
                                           input logic pb, input logic s0);
      logic [15:0] f;
      int p;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < nd; i++) f[1+i] = d[i];
      p = 1 + nd;
      if (hp != 0) begin
         f[p] = pb;
         p++;
      end
      f[p] = s0;
      return f;
   endfunction

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [15:0] f, input int n, input int glitch_at,
                       input int ready_at, input int abort_at);
      for (int i = 0; i < n * CPB; i++) begin
         @(negedge clk);
         if (i == abort_at) begin
            rx    = 1'b1;
            reset = 1'b1;
            return;
         end
         rx = f[i / CPB] ^ (i == glitch_at);
         if (ready_at >= 0) begin
            if (i == ready_at) ready = 1'b1;
            else if (i == ready_at + 1) ready = 1'b0;
         end
      end
   endtask

   initial begin
      int a0, o0, c0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", 32'(v), 32'h0);
      check("rst_flags", 32'({pe, fe, brk, ovr}), 32'h0);
      check("rst_data", 32'({d0, d1, d2, d3}), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(10);

      // 8N1 basic frame, consumer always ready
      sel = 2'd0; ready = 1'b1; a0 = acc_cnt; c0 = vcyc;
      send(mkframe(9'h0A5, 8, 0, 1'b0, 1'b1), 10, -1, -1, -1);
      idle(20);
      check("8n1_acc", 32'(acc_cnt - a0), 32'd1);
      check("8n1_vcyc", 32'(vcyc - c0), 32'd1);
      check("8n1_data", 32'(last_d), 32'h0A5);
      check("8n1_flags", 32'({last_pe, last_fe, last_brk}), 32'h0);

      // parity modes
      sel = 2'd1; a0 = acc_cnt;
      send(mkframe(9'h007, 8, 1, 1'b0, 1'b1), 11, -1, -1, -1);
      idle(20);
      check("8e1_bad_acc", 32'(acc_cnt - a0), 32'd1);
      check("8e1_bad_pe", 32'(last_pe), 32'd1);
      send(mkframe(9'h007, 8, 1, 1'b1, 1'b1), 11, -1, -1, -1);
      idle(20);
      check("8e1_good_pe", 32'(last_pe), 32'd0);
      check("8e1_good_data", 32'(last_d), 32'h007);
      sel = 2'd2; a0 = acc_cnt;
      send(mkframe(9'h007, 8, 1, 1'b0, 1'b1), 11, -1, -1, -1);
      idle(20);
      check("8o1_acc", 32'(acc_cnt - a0), 32'd1);
      check("8o1_pe", 32'(last_pe), 32'd0);

      // stop-bit errors and break
      sel = 2'd0; a0 = acc_cnt;
      send(mkframe(9'h03C, 8, 0, 1'b0, 1'b0), 10, -1, -1, -1);
      idle(40);
      check("ferr_data", 32'(last_d), 32'h03C);
      check("ferr_fe_brk", 32'({last_fe, last_brk}), 32'b10);
      send(mkframe(9'h000, 8, 0, 1'b0, 1'b0), 10, -1, -1, -1);
      idle(40);
      check("brk_fe_brk", 32'({last_fe, last_brk}), 32'b11);
      check("ferr_acc", 32'(acc_cnt - a0), 32'd2);

      // short start glitch and mid-bit glitch rejected by the vote
      a0 = acc_cnt; c0 = vcyc;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(60);
      check("glitch_start_acc", 32'(acc_cnt - a0), 32'd0);
      check("glitch_start_vcyc", 32'(vcyc - c0), 32'd0);
      send(mkframe(9'h000, 8, 0, 1'b0, 1'b1), 10, 3 * CPB + 9, -1, -1);
      idle(20);
      check("glitch_bit_acc", 32'(acc_cnt - a0), 32'd1);
      check("glitch_bit_data", 32'(last_d), 32'h000);

      // back-to-back frames without accept: overrun
      ready = 1'b0; a0 = acc_cnt; o0 = ovr_cnt;
      send(mkframe(9'h011, 8, 0, 1'b0, 1'b1), 10, -1, -1, -1);
      send(mkframe(9'h022, 8, 0, 1'b0, 1'b1), 10, -1, -1, -1);
      idle(20);
      check("ovr_valid", 32'(cv), 32'd1);
      check("ovr_data", 32'(cd), 32'h011);
      check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
      check("ovr_acc", 32'(acc_cnt - a0), 32'd0);
      ready = 1'b1;
      @(negedge clk);
      #1;
      check("accept_drop", 32'(cv), 32'd0);
      check("accept_data", 32'(last_d), 32'h011);
      ready = 1'b0;

      // accept coinciding with a completion
      send(mkframe(9'h033, 8, 0, 1'b0, 1'b1), 10, -1, -1, -1);
      idle(20);
      a0 = acc_cnt; o0 = ovr_cnt;
      send(mkframe(9'h044, 8, 0, 1'b0, 1'b1), 10, -1, 9 * CPB + 12, -1);
      idle(20);
      check("coll_acc", 32'(acc_cnt - a0), 32'd1);
      check("coll_old", 32'(last_d), 32'h033);
      check("coll_new", 32'({cv, cd}), 32'({1'b1, 9'h044}));
      check("coll_ovr", 32'(ovr_cnt - o0), 32'd0);
      ready = 1'b1;
      idle(3);
      ready = 1'b0;

      // 9-bit, 2-stop build: reset mid-frame then a clean frame
      sel = 2'd3;
      send(mkframe(9'h0AB, 9, 0, 1'b0, 1'b1), 12, -1, -1, -1);
      idle(20);
      check("9n2_hold", 32'({cv, cd}), 32'({1'b1, 9'h0AB}));
      send(mkframe(9'h155, 9, 0, 1'b0, 1'b1), 12, -1, -1, 5 * CPB + 4);
      #1;
      check("midrst_valid", 32'(v), 32'h0);
      check("midrst_out", 32'({d3, pe, fe, brk, ovr}), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(20);
      ready = 1'b1; a0 = acc_cnt;
      send(mkframe(9'h1C3, 9, 0, 1'b0, 1'b1), 12, -1, -1, -1);
      idle(40);
      check("9n2_acc", 32'(acc_cnt - a0), 32'd1);
      check("9n2_data", 32'(last_d), 32'h1C3);
      check("9n2_flags", 32'({last_pe, last_fe, last_brk}), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
